// File: rtl/wave_meas_counter_if.sv
// Bundles the control input, waveform input and measurement results of wave_meas_counter.
// Latency: none, wiring only.
// Backpressure: none; results are qualified by the one-cycle meas_valid pulse.
interface wave_meas_counter_if;
    logic        enable;
    logic        sig_in;
    logic [19:0] freq_out;
    logic [6:0]  duty_out;
    logic        overrange;
    logic        meas_valid;
    logic        busy;

    // Stimulus / consumer side
    modport master (
        output enable,
        output sig_in,
        input  freq_out,
        input  duty_out,
        input  overrange,
        input  meas_valid,
        input  busy
    );

    // Measurement block side
    modport slave (
        input  enable,
        input  sig_in,
        output freq_out,
        output duty_out,
        output overrange,
        output meas_valid,
        output busy
    );
endinterface

// File: rtl/wave_meas_counter.sv
// Measures rising-edge count (Hz) and duty cycle (%) of sig_in over a fixed gate window.
// Latency: results and meas_valid appear 8 cycles after the last gate cycle (7 divide + 1 done).
// Backpressure: none; meas_valid is a one-cycle pulse and results hold until the next measurement.
module wave_meas_counter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int FREQ_MAX    = 999999
) (
    input  logic                clk,
    input  logic                rst,
    wave_meas_counter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GATE = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [33:0] DIVISOR   = 34'(GATE_CYCLES);
    localparam logic [26:0] GATE_LAST = 27'(GATE_CYCLES - 1);
    localparam logic [25:0] FREQ_CEIL = 26'(FREQ_MAX);

    logic [1:0]  state;
    logic        s1, s2, s3;
    logic        rise;
    logic [26:0] gate_cnt;
    logic [25:0] edge_cnt;
    logic [26:0] high_cnt;
    logic [26:0] high_next;
    logic [33:0] dividend;
    logic [33:0] rem;
    logic [33:0] div_shift;
    logic        div_ge;
    logic [6:0]  quot;
    logic [6:0]  quot_next;
    logic [2:0]  div_idx;
    logic        over_max;

    logic [19:0] freq_reg;
    logic [6:0]  duty_reg;
    logic        over_reg;
    logic        valid_reg;

    assign rise = s2 & ~s3;

    // The last gate cycle's high sample must be folded into the dividend as it is loaded.
    assign high_next = high_cnt + {26'd0, s2};
    assign dividend  = 34'(high_next) * 34'd100;

    // One restoring-division step per DIV cycle, quotient bit 6 first.
    assign div_shift = DIVISOR << div_idx;
    assign div_ge    = (rem >= div_shift);
    assign quot_next = {quot[5:0], div_ge};
    assign over_max  = (edge_cnt > FREQ_CEIL);

    assign bus.freq_out   = freq_reg;
    assign bus.duty_out   = duty_reg;
    assign bus.overrange  = over_reg;
    assign bus.meas_valid = valid_reg;
    assign bus.busy       = (state == ST_GATE) || (state == ST_DIV);

    // Two-flop synchronizer plus one history stage for rising-edge detection; runs in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Measurement sequencer: gate counting, duty division, result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            high_cnt  <= '0;
            rem       <= '0;
            quot      <= '0;
            div_idx   <= '0;
            freq_reg  <= '0;
            duty_reg  <= '0;
            over_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state    <= ST_GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        high_cnt <= '0;
                    end
                end
                ST_GATE: begin
                    if (!bus.enable) begin
                        // Abandon the partial gate; previous results stay on the outputs.
                        state <= ST_IDLE;
                    end else begin
                        gate_cnt <= gate_cnt + 27'd1;
                        edge_cnt <= edge_cnt + {25'd0, rise};
                        high_cnt <= high_next;
                        if (gate_cnt == GATE_LAST) begin
                            state   <= ST_DIV;
                            rem     <= dividend;
                            quot    <= '0;
                            div_idx <= 3'd6;
                        end
                    end
                end
                ST_DIV: begin
                    quot    <= quot_next;
                    div_idx <= div_idx - 3'd1;
                    if (div_ge) begin
                        rem <= rem - div_shift;
                    end
                    if (div_idx == 3'd0) begin
                        // Results are loaded here so they are visible during the DONE cycle.
                        state     <= ST_DONE;
                        duty_reg  <= quot_next;
                        freq_reg  <= over_max ? FREQ_CEIL[19:0] : edge_cnt[19:0];
                        over_reg  <= over_max;
                        valid_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.enable) begin
                        state    <= ST_GATE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        high_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_meas_counter.sv
// Self-checking bench for wave_meas_counter: three instances cover the nominal,
// saturating and short-gate configurations; expected results go through a scoreboard queue.
module tb_wave_meas_counter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [19:0] f;
        logic [6:0]  d;
        logic        o;
    } exp_t;

    exp_t sb_q[$];

    // Waveform generator settings: period and number of high cycles per period.
    int per_a = 100, hi_a = 0;
    int per_s = 10,  hi_s = 5;
    int per_r = 3,   hi_r = 1;

    wave_meas_counter_if ifa ();
    wave_meas_counter_if ifs ();
    wave_meas_counter_if ifr ();

    wave_meas_counter #(.GATE_CYCLES(1000), .FREQ_MAX(999999)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    wave_meas_counter #(.GATE_CYCLES(1000), .FREQ_MAX(5))      dut_s (.clk(clk), .rst(rst), .bus(ifs));
    wave_meas_counter #(.GATE_CYCLES(300),  .FREQ_MAX(999999)) dut_r (.clk(clk), .rst(rst), .bus(ifr));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int ph;
        ph = 0;
        ifa.sig_in = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1 >= per_a) ? 0 : ph + 1;
            ifa.sig_in = (ph < hi_a);
        end
    end

    initial begin
        int ph;
        ph = 0;
        ifs.sig_in = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1 >= per_s) ? 0 : ph + 1;
            ifs.sig_in = (ph < hi_s);
        end
    end

    initial begin
        int ph;
        ph = 0;
        ifr.sig_in = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1 >= per_r) ? 0 : ph + 1;
            ifr.sig_in = (ph < hi_r);
        end
    end

    // Waits (bounded) for meas_valid on the selected instance and captures its results.
    task automatic wait_valid(input int sel, input int budget, output bit got, output int at,
                              output logic [19:0] f, output logic [6:0] d, output logic o);
        got = 1'b0;
        at  = 0;
        f   = '0;
        d   = '0;
        o   = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            case (sel)
                0: if (ifa.meas_valid) begin got = 1'b1; at = cyc; f = ifa.freq_out; d = ifa.duty_out; o = ifa.overrange; end
                1: if (ifs.meas_valid) begin got = 1'b1; at = cyc; f = ifs.freq_out; d = ifs.duty_out; o = ifs.overrange; end
                default: if (ifr.meas_valid) begin got = 1'b1; at = cyc; f = ifr.freq_out; d = ifr.duty_out; o = ifr.overrange; end
            endcase
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.enable = 1'b0;
        ifs.enable = 1'b0;
        ifr.enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifa.freq_out !== 20'd0) begin errors++; $display("FAIL reset_freq got %0d want 0", ifa.freq_out); end
        checks++; if (ifa.duty_out !== 7'd0) begin errors++; $display("FAIL reset_duty got %0d want 0", ifa.duty_out); end
        checks++; if (ifa.overrange !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", ifa.overrange); end
        checks++; if (ifa.meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifa.meas_valid); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifa.busy); end
        checks++; if (ifs.busy !== 1'b0 || ifr.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_sr got %b%b want 00", ifs.busy, ifr.busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_periodic();
        exp_t e;
        bit got;
        int t1, t2;
        logic [19:0] f;
        logic [6:0] d;
        logic o;
        per_a = 100;
        hi_a  = 25;
        repeat (200) @(negedge clk);
        ifa.enable = 1'b1;
        sb_q.push_back('{f: 20'd10, d: 7'd25, o: 1'b0});
        sb_q.push_back('{f: 20'd10, d: 7'd25, o: 1'b0});
        wait_valid(0, 1200, got, t1, f, d, o);
        e = sb_q.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL periodic_valid1 no meas_valid within 1200 cycles"); end
        checks++; if (f !== e.f) begin errors++; $display("FAIL periodic_freq1 got %0d want %0d", f, e.f); end
        checks++; if (d !== e.d) begin errors++; $display("FAIL periodic_duty1 got %0d want %0d", d, e.d); end
        checks++; if (o !== e.o) begin errors++; $display("FAIL periodic_ovr1 got %b want %b", o, e.o); end
        @(negedge clk);
        checks++; if (ifa.meas_valid !== 1'b0) begin errors++; $display("FAIL periodic_pulse_width got %b want 0", ifa.meas_valid); end
        wait_valid(0, 1200, got, t2, f, d, o);
        e = sb_q.pop_front();
        ifa.enable = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL periodic_valid2 no meas_valid within 1200 cycles"); end
        checks++; if (t2 - t1 !== 1008) begin errors++; $display("FAIL periodic_spacing got %0d want 1008", t2 - t1); end
        checks++; if (f !== e.f) begin errors++; $display("FAIL periodic_freq2 got %0d want %0d", f, e.f); end
        checks++; if (d !== e.d) begin errors++; $display("FAIL periodic_duty2 got %0d want %0d", d, e.d); end
        @(negedge clk);
    endtask

    task automatic test_reset_running();
        int seen;
        ifa.enable = 1'b1;
        repeat (500) @(negedge clk);
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL rst_gate_busy_before got %b want 1", ifa.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ifa.freq_out !== 20'd0) begin errors++; $display("FAIL rst_gate_freq got %0d want 0", ifa.freq_out); end
        checks++; if (ifa.duty_out !== 7'd0) begin errors++; $display("FAIL rst_gate_duty got %0d want 0", ifa.duty_out); end
        checks++; if (ifa.overrange !== 1'b0 || ifa.meas_valid !== 1'b0) begin errors++; $display("FAIL rst_gate_flags got %b%b want 00", ifa.overrange, ifa.meas_valid); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_gate_busy got %b want 0", ifa.busy); end
        // Enable is still high: one IDLE cycle, 1000 gate cycles, then the divider.
        repeat (1003) @(negedge clk);
        checks++; if (ifa.busy !== 1'b1 || ifa.meas_valid !== 1'b0) begin errors++; $display("FAIL rst_div_before got busy %b valid %b want 1 0", ifa.busy, ifa.meas_valid); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ifa.busy !== 1'b0 || ifa.meas_valid !== 1'b0 || ifa.freq_out !== 20'd0) begin errors++; $display("FAIL rst_div_state got busy %b valid %b freq %0d want 0 0 0", ifa.busy, ifa.meas_valid, ifa.freq_out); end
        ifa.enable = 1'b0;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (ifa.meas_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_valid got %0d pulses want 0", seen); end
    endtask

    task automatic test_static();
        exp_t e;
        bit got;
        int t;
        logic [19:0] f;
        logic [6:0] d;
        logic o;
        per_a = 1;
        hi_a  = 1;
        repeat (20) @(negedge clk);
        ifa.enable = 1'b1;
        sb_q.push_back('{f: 20'd0, d: 7'd100, o: 1'b0});
        wait_valid(0, 1200, got, t, f, d, o);
        ifa.enable = 1'b0;
        e = sb_q.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL high_valid no meas_valid within 1200 cycles"); end
        checks++; if (f !== e.f) begin errors++; $display("FAIL high_freq got %0d want %0d", f, e.f); end
        checks++; if (d !== e.d) begin errors++; $display("FAIL high_duty got %0d want %0d", d, e.d); end
        hi_a = 0;
        repeat (20) @(negedge clk);
        ifa.enable = 1'b1;
        sb_q.push_back('{f: 20'd0, d: 7'd0, o: 1'b0});
        wait_valid(0, 1200, got, t, f, d, o);
        ifa.enable = 1'b0;
        e = sb_q.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL low_valid no meas_valid within 1200 cycles"); end
        checks++; if (f !== e.f) begin errors++; $display("FAIL low_freq got %0d want %0d", f, e.f); end
        checks++; if (d !== e.d) begin errors++; $display("FAIL low_duty got %0d want %0d", d, e.d); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        exp_t e;
        bit got;
        int t;
        logic [19:0] f;
        logic [6:0] d;
        logic o;
        ifs.enable = 1'b1;
        sb_q.push_back('{f: 20'd5, d: 7'd50, o: 1'b1});
        wait_valid(1, 1200, got, t, f, d, o);
        ifs.enable = 1'b0;
        e = sb_q.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL sat_valid no meas_valid within 1200 cycles"); end
        checks++; if (f !== e.f) begin errors++; $display("FAIL sat_freq got %0d want %0d", f, e.f); end
        checks++; if (d !== e.d) begin errors++; $display("FAIL sat_duty got %0d want %0d", d, e.d); end
        checks++; if (o !== e.o) begin errors++; $display("FAIL sat_ovr got %b want %b", o, e.o); end
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        exp_t e;
        bit got;
        int t, t0, seen;
        logic [19:0] f;
        logic [6:0] d;
        logic o;
        per_a = 100;
        hi_a  = 25;
        repeat (200) @(negedge clk);
        ifa.enable = 1'b1;
        sb_q.push_back('{f: 20'd10, d: 7'd25, o: 1'b0});
        wait_valid(0, 1200, got, t, f, d, o);
        e = sb_q.pop_front();
        checks++; if (!got || f !== e.f) begin errors++; $display("FAIL drop_first_freq got %0d valid %b want %0d", f, got, e.f); end
        // Enable stays high, so the next gate starts; drop it while gate_cnt is 500.
        repeat (501) @(negedge clk);
        ifa.enable = 1'b0;
        @(negedge clk);
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", ifa.busy); end
        seen = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (ifa.meas_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL drop_no_valid got %0d pulses want 0", seen); end
        checks++; if (ifa.freq_out !== 20'd10) begin errors++; $display("FAIL drop_freq_hold got %0d want 10", ifa.freq_out); end
        // Re-raise: IDLE cycle that samples enable, 1000 gate cycles, 7 divide cycles, then DONE.
        ifa.enable = 1'b1;
        t0 = cyc;
        sb_q.push_back('{f: 20'd10, d: 7'd25, o: 1'b0});
        wait_valid(0, 1200, got, t, f, d, o);
        ifa.enable = 1'b0;
        e = sb_q.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL drop_restart_valid no meas_valid within 1200 cycles"); end
        checks++; if (t - t0 !== 1008) begin errors++; $display("FAIL drop_restart_latency got %0d want 1008", t - t0); end
        checks++; if (f !== e.f || d !== e.d) begin errors++; $display("FAIL drop_restart_result got %0d/%0d want %0d/%0d", f, d, e.f, e.d); end
        @(negedge clk);
    endtask

    task automatic test_duty_rounding();
        exp_t e;
        bit got;
        int t;
        logic [19:0] f;
        logic [6:0] d;
        logic o;
        ifr.enable = 1'b1;
        sb_q.push_back('{f: 20'd100, d: 7'd33, o: 1'b0});
        wait_valid(2, 500, got, t, f, d, o);
        ifr.enable = 1'b0;
        e = sb_q.pop_front();
        checks++; if (!got) begin errors++; $display("FAIL round_valid no meas_valid within 500 cycles"); end
        checks++; if (d !== e.d) begin errors++; $display("FAIL round_duty got %0d want %0d", d, e.d); end
        checks++; if (f !== e.f) begin errors++; $display("FAIL round_freq got %0d want %0d", f, e.f); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_reset_running();
        test_static();
        test_saturation();
        test_enable_drop();
        test_duty_rounding();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
